// File: rtl/wb_matmul_nxn_if.sv
// Wishbone-classic bus bundle for the NxN matrix-multiply accelerator.
`timescale 1ns/1ps
interface wb_matmul_nxn_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  wb_sel;
    logic [31:0] adr;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, wb_sel, adr, dat_mosi,
        input  dat_miso, ack, err
    );

    modport slave (
        input  cyc, stb, we, wb_sel, adr, dat_mosi,
        output dat_miso, ack, err
    );
endinterface

// File: rtl/wb_matmul_nxn.sv
// Wishbone-classic slave holding two NxN unsigned matrices A and B and
// computing C = A x B with a single time-multiplexed multiply-accumulate.
// Each C element takes N MAC cycles plus one STORE cycle, so a run keeps
// busy high for N*N*(N+1) cycles. Reads of C stall until done is set.
`timescale 1ns/1ps
module wb_matmul_nxn #(
    parameter int N    = 3,
    parameter int DW   = 8,
    parameter int ACCW = 2*DW + $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    wb_matmul_nxn_if.slave  bus,
    output logic            irq
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam logic [31:0] B_BASE   = 32'(NN);
    localparam logic [31:0] C_BASE   = 32'(2 * NN);
    localparam logic [31:0] CTRL_ADR = 32'(3 * NN);
    localparam logic [31:0] STAT_ADR = 32'(3 * NN + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_STORE} state_t;

    logic [DW-1:0]   mat_a [NN];
    logic [DW-1:0]   mat_b [NN];
    logic [ACCW-1:0] mat_c [NN];

    logic busy, done, ie;

    // bus decode
    logic          req, is_a, is_b, is_c;
    logic [IW-1:0] idx_a, idx_b, idx_c;
    logic          resp_ack, resp_err;
    logic [31:0]   rd_data;
    logic          wr_a, wr_b, wr_ctrl, start_go;

    // engine
    state_t          state, state_nx;
    logic            fin;
    logic [IW-1:0]   i_cnt, j_cnt, k_cnt;
    logic [IW-1:0]   a_idx, b_idx, c_idx;
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc;
    logic            k_last, el_last;

    // Bits of the write data and byte select that no register uses.
    logic unused_bits;
    assign unused_bits = ^{bus.wb_sel[3:1], bus.dat_mosi[31:DW]};

    // A new request only counts while no response is on the bus, so the
    // response cycle can never be re-sampled as a second request.
    assign req   = bus.cyc && bus.stb && !bus.ack && !bus.err;
    assign is_a  = bus.adr < B_BASE;
    assign is_b  = (bus.adr >= B_BASE) && (bus.adr < C_BASE);
    assign is_c  = (bus.adr >= C_BASE) && (bus.adr < CTRL_ADR);
    assign idx_a = IW'(bus.adr);
    assign idx_b = IW'(bus.adr - B_BASE);
    assign idx_c = IW'(bus.adr - C_BASE);

    assign irq = done && ie;

    // Decode the current request into a response and register-write strobes.
    always_comb begin
        resp_ack = 1'b0;
        resp_err = 1'b0;
        rd_data  = '0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        wr_ctrl  = 1'b0;
        start_go = 1'b0;
        if (req) begin
            if (bus.we) begin
                if (is_a || is_b) begin
                    if (busy) begin
                        resp_err = 1'b1;
                    end else begin
                        resp_ack = 1'b1;
                        wr_a     = is_a && bus.wb_sel[0];
                        wr_b     = is_b && bus.wb_sel[0];
                    end
                end else if (bus.adr == CTRL_ADR) begin
                    if (busy && bus.dat_mosi[0]) begin
                        resp_err = 1'b1;
                    end else begin
                        resp_ack = 1'b1;
                        wr_ctrl  = 1'b1;
                        start_go = bus.dat_mosi[0];
                    end
                end else begin
                    resp_err = 1'b1;
                end
            end else begin
                if (is_a) begin
                    resp_ack = 1'b1;
                    rd_data  = 32'(mat_a[idx_a]);
                end else if (is_b) begin
                    resp_ack = 1'b1;
                    rd_data  = 32'(mat_b[idx_b]);
                end else if (is_c) begin
                    // Without done the read simply stalls; no response at all.
                    if (done) begin
                        resp_ack = 1'b1;
                        rd_data  = 32'(mat_c[idx_c]);
                    end
                end else if (bus.adr == CTRL_ADR) begin
                    resp_ack = 1'b1;
                    rd_data  = {30'b0, ie, 1'b0};
                end else if (bus.adr == STAT_ADR) begin
                    resp_ack = 1'b1;
                    rd_data  = {30'b0, done, busy};
                end else begin
                    resp_err = 1'b1;
                end
            end
        end
    end

    // Registered bus response; read data only changes with a read ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack      <= 1'b0;
            bus.err      <= 1'b0;
            bus.dat_miso <= '0;
        end else begin
            bus.ack <= resp_ack;
            bus.err <= resp_err;
            if (resp_ack && !bus.we) begin
                bus.dat_miso <= rd_data;
            end
        end
    end

    // Operand storage written from the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NN; e++) begin
                mat_a[e] <= '0;
                mat_b[e] <= '0;
            end
        end else begin
            if (wr_a) mat_a[idx_a] <= bus.dat_mosi[DW-1:0];
            if (wr_b) mat_b[idx_b] <= bus.dat_mosi[DW-1:0];
        end
    end

    // Control/status flags: start sets busy, engine finish sets done,
    // any operand change invalidates the previous result.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            ie   <= 1'b0;
        end else begin
            if (wr_ctrl) ie <= bus.dat_mosi[1];
            if (start_go) begin
                busy <= 1'b1;
                done <= 1'b0;
            end
            if (fin) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (wr_a || wr_b) done <= 1'b0;
        end
    end

    assign k_last  = k_cnt == IW'(N - 1);
    assign el_last = (i_cnt == IW'(N - 1)) && (j_cnt == IW'(N - 1));
    assign a_idx   = i_cnt * IW'(N) + k_cnt;
    assign b_idx   = k_cnt * IW'(N) + j_cnt;
    assign c_idx   = i_cnt * IW'(N) + j_cnt;
    assign prod    = mat_a[a_idx] * mat_b[b_idx];

    // Engine state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Engine next state; the final STORE also completes the run (done state
    // is folded into that transition so busy ends exactly on schedule).
    always_comb begin
        state_nx = state;
        fin      = 1'b0;
        case (state)
            ST_IDLE:  if (start_go) state_nx = ST_MAC;
            ST_MAC:   if (k_last) state_nx = ST_STORE;
            ST_STORE: begin
                if (el_last) begin
                    state_nx = ST_IDLE;
                    fin      = 1'b1;
                end else begin
                    state_nx = ST_MAC;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Engine datapath: index counters, accumulator and C write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
            acc   <= '0;
            for (int e = 0; e < NN; e++) mat_c[e] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    k_cnt <= '0;
                end
                ST_MAC: begin
                    acc   <= ((k_cnt == '0) ? '0 : acc) + ACCW'(prod);
                    k_cnt <= k_last ? '0 : k_cnt + 1'b1;
                end
                ST_STORE: begin
                    mat_c[c_idx] <= acc;
                    if (j_cnt == IW'(N - 1)) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_matmul_nxn.sv
// Directed bench for wb_matmul_nxn: a 3x3/8-bit instance and a 4x4/4-bit
// instance share one bus driver, selected by dsel.
`timescale 1ns/1ps
module tb_wb_matmul_nxn;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        dsel;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack, err, irq, irq3, irq4;
    logic [31:0] miso;

    wb_matmul_nxn_if bus3();
    wb_matmul_nxn_if bus4();

    assign bus3.cyc      = cyc && !dsel;
    assign bus3.stb      = stb;
    assign bus3.we       = we;
    assign bus3.wb_sel   = sel;
    assign bus3.adr      = adr;
    assign bus3.dat_mosi = wdat;
    assign bus4.cyc      = cyc && dsel;
    assign bus4.stb      = stb;
    assign bus4.we       = we;
    assign bus4.wb_sel   = sel;
    assign bus4.adr      = adr;
    assign bus4.dat_mosi = wdat;

    assign ack  = dsel ? bus4.ack : bus3.ack;
    assign err  = dsel ? bus4.err : bus3.err;
    assign miso = dsel ? bus4.dat_miso : bus3.dat_miso;
    assign irq  = dsel ? irq4 : irq3;

    wb_matmul_nxn #(.N(3), .DW(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .irq(irq3));
    wb_matmul_nxn #(.N(4), .DW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .irq(irq4));

    int checks = 0;
    int errors = 0;
    int n = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction, bounded by limit clock edges; returns response.
    task automatic xfer(input logic w, input int a, input logic [31:0] d, input logic [3:0] s,
                        input int limit, output logic [31:0] rd, output logic [1:0] resp,
                        output int ncyc);
        cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(a); wdat = d; sel = s;
        ncyc = 0; resp = 2'b00;
        while (ncyc < limit && resp == 2'b00) begin
            @(posedge clk); #1;
            ncyc++;
            resp = {err, ack};
        end
        rd  = miso;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input int a, input logic [31:0] d, input logic [3:0] s,
                      input logic exp_err);
        logic [31:0] rd; logic [1:0] resp; int nc;
        xfer(1'b1, a, d, s, 20, rd, resp, nc);
        check({tag, " resp"}, 32'(resp), exp_err ? 32'h2 : 32'h1);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] rd; logic [1:0] resp; int nc;
        xfer(1'b0, a, 32'h0, 4'hF, 20, rd, resp, nc);
        check({tag, " resp"}, 32'(resp), exp_err ? 32'h2 : 32'h1);
        if (!exp_err) check({tag, " data"}, rd, exp);
    endtask

    task automatic pulse_gap(input string tag);
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'({err, ack}), 32'h0);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] rd; logic [1:0] resp; int nc; int tries;
        tries = 0;
        rd = 32'h0;
        while (rd != 32'h2 && tries < 100) begin
            xfer(1'b0, 3*n*n + 1, 32'h0, 4'hF, 20, rd, resp, nc);
            tries++;
        end
        check({tag, " done"}, rd, 32'h2);
    endtask

    // Start, then immediately read C[idx]; the read must stall for the whole
    // busy window and be acked the cycle after done rises.
    task automatic stall_read(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] rd; logic [1:0] resp; int nc;
        wr({tag, " start"}, 3*n*n, 32'h1, 4'h1, 1'b0);
        xfer(1'b0, 2*n*n + idx, 32'h0, 4'hF, 400, rd, resp, nc);
        check({tag, " resp"}, 32'(resp), 32'h1);
        check({tag, " latency"}, 32'(nc), 32'(n*n*(n+1) + 1));
        check({tag, " data"}, rd, exp);
    endtask

    initial begin
        rst = 1'b1; dsel = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state, both instances
        check("rst ack3", 32'(ack), 32'h0);
        check("rst err3", 32'(err), 32'h0);
        check("rst irq3", 32'(irq), 32'h0);
        check("rst miso3", miso, 32'h0);
        rd_chk("rst status3", 28, 32'h0, 1'b0);
        rd_chk("rst ctrl3", 27, 32'h0, 1'b0);

        // 1: identity x {1..9}
        for (int e = 0; e < 9; e++) begin
            wr("A id", e, (e % 4 == 0) ? 32'h1 : 32'h0, 4'h1, 1'b0);
            wr("B seq", 9 + e, 32'(e + 1), 4'h1, 1'b0);
        end
        wr("start1", 27, 32'h1, 4'h1, 1'b0);
        rd_chk("status busy", 28, 32'h1, 1'b0);
        wait_done("t1");
        for (int e = 0; e < 9; e++) rd_chk($sformatf("t1 C%0d", e), 18 + e, 32'(e + 1), 1'b0);
        check("t1 irq", 32'(irq), 32'h0);

        // 3: stalled read of C[4] across a full run
        stall_read("t3", 4, 32'h5);

        // 2: all-255 operands, interrupts enabled
        for (int e = 0; e < 18; e++) wr("ff", e, 32'hFF, 4'h1, 1'b0);
        wr("start2", 27, 32'h3, 4'h1, 1'b0);
        wait_done("t2");
        check("t2 irq on", 32'(irq), 32'h1);
        for (int e = 0; e < 9; e++) rd_chk($sformatf("t2 C%0d", e), 18 + e, 32'h2FA03, 1'b0);
        rd_chk("t2 ctrl", 27, 32'h2, 1'b0);
        wr("t2 A0", 0, 32'h1, 4'h1, 1'b0);
        check("t2 irq off", 32'(irq), 32'h0);
        rd_chk("t2 status", 28, 32'h0, 1'b0);

        // 4: illegal accesses while busy
        wr("t4 start", 27, 32'h3, 4'h1, 1'b0);
        wr("t4 wrA", 0, 32'h55, 4'h1, 1'b1);
        pulse_gap("t4 wrA");
        wr("t4 wrCTRL", 27, 32'h1, 4'h1, 1'b1);
        pulse_gap("t4 wrCTRL");
        wr("t4 wrC", 18, 32'h7, 4'h1, 1'b1);
        pulse_gap("t4 wrC");
        rd_chk("t4 rd29", 29, 32'h0, 1'b1);
        pulse_gap("t4 rd29");
        wr("t4 wrSTAT", 28, 32'h0, 4'h1, 1'b1);
        wait_done("t4");
        rd_chk("t4 A0 kept", 0, 32'h1, 1'b0);
        rd_chk("t4 ie kept", 27, 32'h2, 1'b0);
        rd_chk("t4 C0", 18, 32'd130305, 1'b0);

        // 5: byte-select gating and truncation to DW
        wr("t5 wr1FF", 0, 32'h1FF, 4'h1, 1'b0);
        rd_chk("t5 rdFF", 0, 32'hFF, 1'b0);
        wr("t5 sel0", 0, 32'h12, 4'h0, 1'b0);
        rd_chk("t5 kept", 0, 32'hFF, 1'b0);

        // 6: reset in the middle of a run
        wr("t6 start", 27, 32'h1, 4'h1, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6 miso", miso, 32'h0);
        check("t6 irq", 32'(irq), 32'h0);
        rd_chk("t6 status", 28, 32'h0, 1'b0);
        rd_chk("t6 ctrl", 27, 32'h0, 1'b0);
        rd_chk("t6 B0", 9, 32'h0, 1'b0);
        for (int e = 0; e < 9; e++) wr("t6 A0s", e, 32'h0, 4'h1, 1'b0);
        wr("t6 start2", 27, 32'h1, 4'h1, 1'b0);
        wait_done("t6");
        for (int e = 0; e < 9; e++) rd_chk($sformatf("t6 C%0d", e), 18 + e, 32'h0, 1'b0);

        // 6b: 4x4 / 4-bit instance, identity x {0..15}
        dsel = 1'b1; n = 4;
        rd_chk("n4 status", 49, 32'h0, 1'b0);
        for (int e = 0; e < 16; e++) begin
            wr("n4 A", e, (e % 5 == 0) ? 32'h1 : 32'h0, 4'h1, 1'b0);
            wr("n4 B", 16 + e, 32'(e), 4'h1, 1'b0);
        end
        stall_read("n4", 5, 32'h5);
        for (int e = 0; e < 16; e++) rd_chk($sformatf("n4 C%0d", e), 32 + e, 32'(e), 1'b0);
        rd_chk("n4 rd50", 50, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_matmul_nxn.md
Name: wb_matmul_nxn

Overview:
Wishbone-classic slave that holds two NxN unsigned matrices A and B and computes C = A x B with one time-multiplexed multiply-accumulate engine.
- Generalises the fixed 3x3 / 8-bit multiplier peripheral: size and element width are parameters, results are full precision, and start/busy/done are explicit registers.
- Reads of C stall until results are valid.
- Sits on the SoC data bus as a memory-mapped accelerator.

Parameters:
N, 3, matrix dimension (2..8)
DW, 8, element width of A and B in bits (1..16)
ACCW, 2*DW+$clog2(N)+1, result width; must be <= 32; C elements are zero-extended into dat_miso

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cyc  input  1  bus cycle valid
stb  input  1  strobe
we  input  1  1=write, 0=read
wb_sel  input  4  byte select; bit0 gates writes
adr  input  32  word address
dat_mosi  input  32  write data
dat_miso  output  32  read data, registered
ack  output  1  acknowledge, one-cycle pulse
err  output  1  error, one-cycle pulse
irq  output  1  level, high while done=1 and CTRL.ie=1

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset: dat_miso=0, ack=0, err=0, irq=0, busy=0, done=0, ie=0, A/B/C arrays=0, engine=IDLE. Reset mid-computation aborts it; no C writes after reset.
- Address map (word addresses, row-major, element [r][c] at base + r*N + c):
  - A: 0..N*N-1.
  - B: N*N..2N*N-1.
  - C: 2N*N..3N*N-1.
  - CTRL: 3N*N. Write bit0=start (self-clearing), bit1=ie. Read returns {30'b0, ie, 0}.
  - STATUS: 3N*N+1. Read-only, {30'b0, done, busy}.
- Bus handshake:
  - A request is cyc&&stb with ack=0 and err=0.
  - Response is registered: ack or err asserts on the cycle after the request is sampled, for exactly one cycle.
  - ack and err are never both high.
  - One response per request. The cycle after a response is never treated as a new request, even if stb stays high.
  - dat_miso updates only with a read ack; it holds its value otherwise.
- Writes:
  - A/B write with wb_sel[0]=1 stores dat_mosi[DW-1:0] and clears done.
  - A/B write with wb_sel[0]=0 is acked with no change.
  - A/B write while busy gets err with no change.
  - Write to C or STATUS, or any address >= 3N*N+2, gets err.
  - CTRL write while busy with start=1 gets err; ie is still not updated.
  - CTRL write start=1 when idle: ack, busy=1 and done=0 from the next cycle, engine starts.
- Reads:
  - A, B, CTRL and STATUS read at any time, ack next cycle, zero-extended.
  - C read while busy or before done: no response (stall) until done=1, then ack with data on the cycle after done rises. err is never used for this case.
  - Dropping cyc during a stall cancels the request with no response.
  - C read with done=1: ack next cycle.
  - C read after reset with done never set: stalls indefinitely (master timeout responsibility).
- Engine FSM:
  - IDLE -> MAC on start.
  - MAC: each cycle acc += A[i][k]*B[k][j], k=0..N-1 (acc cleared on entering element).
  - STORE: C[i][j] <= acc, then advance j, then i. Go to MAC, or to DONE after i=j=N-1.
  - DONE: busy=0, done=1, -> IDLE in the same transition.
  - Busy lasts exactly N*N*(N+1) cycles (36 for N=3).
  - Unsigned arithmetic, full precision. Product is 2*DW bits, accumulator ACCW bits, no overflow possible.
- Simultaneous events: rst dominates all. A bus write arriving in the cycle busy rises is seen as busy and errs.

Test Plan:
1. N=3, DW=8. A=identity, B={1..9}, start, poll STATUS -> busy for 36 cycles, then STATUS=0x2. C reads return 1..9. irq=0 (ie=0).
2. A=B=all 255, CTRL=0x3 -> C[all]=195075 (0x2FA03) on dat_miso. irq=1 after done, drops when A is rewritten (done cleared).
3. Start, immediately read C[4] -> no ack during busy. ack with correct value exactly one cycle after done rises; no err.
4. While busy: write A[0] -> err, A unchanged. Write CTRL start -> err. Write C[0] -> err. Read address 3N*N+2=29 -> err. Each response is a single-cycle pulse.
5. Write A[0]=0x1FF with wb_sel=0x1 -> reads back 0xFF. Write with wb_sel=0x0 -> ack, value unchanged.
6. Assert rst for 1 cycle mid-computation (cycle 10) -> busy=0, done=0, C reads all 0 after a fresh start with zeroed A. Repeat with N=4, DW=4 parameters: identity test -> 80-cycle busy window.
